ram_port_ctrl: RTL and testbench



---
 rtl/ram_port_ctrl_pkg.sv | 7 +
 rtl/ram_port_ctrl_if.sv | 31 +++
 rtl/ram_port_ctrl.sv | 64 ++++++
 tb/tb_ram_port_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ram_port_ctrl_pkg.sv
// ram_port_ctrl_pkg: shared encodings and RAM geometry defaults for the RAM port controller
package ram_port_ctrl_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 7;
    typedef enum logic {INIT, RUN} state_e;
    typedef enum logic {WRITE, READ} prio_e;
endpackage

// File: rtl/ram_port_ctrl_if.sv
// ram_port_ctrl_if: request/response and RAM-side bundle of the RAM port controller
// master: requester/RAM side (drives clr, wr_*, rd_* requests and ram_q)
// slave:  controller side (drives busy, readies, rsp_*, ram_we/ram_address/ram_d)
interface ram_port_ctrl_if import ram_port_ctrl_pkg::*; #(
    parameter int DW = DATA_WIDTH_DEF,
    parameter int AW = ADDR_WIDTH_DEF
) ();
    logic          clr;
    logic          busy;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          ram_we;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;
    modport master (
        output clr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_q,
        input  busy, wr_ready, rd_ready, rsp_valid, rsp_data, ram_we, ram_address, ram_d
    );
    modport slave (
        input  clr, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_q,
        output busy, wr_ready, rd_ready, rsp_valid, rsp_data, ram_we, ram_address, ram_d
    );
endinterface

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: owns the single RAM port; zero-fills it, arbitrates writes/reads, returns read data
// clk, reset : clock and synchronous active-high reset
// bus        : slave side of ram_port_ctrl_if (clr/busy, wr_*, rd_*, rsp_*, ram_*)
module ram_port_ctrl import ram_port_ctrl_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input logic            clk,
    input logic            reset,
    ram_port_ctrl_if.slave bus
);
    state_e                state_q;
    prio_e                 prio_q;
    logic [ADDR_WIDTH-1:0] init_cnt_q, addr_q, addr_d;
    logic                  rd_pend_q, rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  run, wr_ok, rd_ok, wr_gnt, rd_gnt;
    always_comb begin
        // a clr cycle in RUN grants nothing
        run    = ~reset & (state_q == RUN) & ~bus.clr;
        wr_ok  = run & (~bus.rd_valid | (prio_q == WRITE));
        rd_ok  = run & (~bus.wr_valid | (prio_q == READ));
        wr_gnt = wr_ok & bus.wr_valid;
        rd_gnt = rd_ok & bus.rd_valid;
        // idle cycles keep the last address on the port
        addr_d = (state_q == INIT) ? init_cnt_q :
                 wr_gnt ? bus.wr_addr :
                 rd_gnt ? bus.rd_addr : addr_q;
    end
    assign bus.busy        = state_q == INIT;
    assign bus.wr_ready    = wr_ok;
    assign bus.rd_ready    = rd_ok;
    assign bus.ram_we      = ~reset & ((state_q == INIT) | wr_gnt);
    assign bus.ram_address = addr_d;
    assign bus.ram_d       = (state_q == INIT) ? '0 : bus.wr_data;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            prio_q      <= WRITE;
            addr_q      <= '0;
            rd_pend_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (state_q == INIT) begin
                init_cnt_q <= init_cnt_q + 1'b1;
                if (&init_cnt_q) state_q <= RUN;
            end else if (bus.clr) begin
                state_q    <= INIT;
                init_cnt_q <= '0;
            end
            // priority only moves on a real conflict
            if (run & bus.wr_valid & bus.rd_valid) prio_q <= (prio_q == WRITE) ? READ : WRITE;
            addr_q      <= addr_d;
            // RAM q is valid the cycle after the read address is captured
            rd_pend_q   <= rd_gnt;
            rsp_valid_q <= rd_pend_q;
            if (rd_pend_q) rsp_data_q <= bus.ram_q;
        end
    end
endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: directed bench for ram_port_ctrl with a behavioural 128x32 RAM
module tb_ram_port_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic poison = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    ram_port_ctrl_if bus ();
    ram_port_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    logic [31:0] mem [128];
    logic [6:0]  ram_a_q;
    always @(posedge clk) begin
        if (poison) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'hFFFF_FFFF;
        end else if (bus.ram_we) begin
            mem[bus.ram_address] <= bus.ram_d;
        end
        ram_a_q <= bus.ram_address;
    end
    assign bus.ram_q = mem[ram_a_q];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic fill(input int n, input int clr_at);
        for (int i = 0; i < n; i++) begin
            bus.clr = (i == clr_at);
            #1;
            chk("fill_busy", 32'(bus.busy), 32'd1);
            chk("fill_we", 32'(bus.ram_we), 32'd1);
            chk("fill_addr", 32'(bus.ram_address), 32'(i));
            chk("fill_d", bus.ram_d, 32'd0);
            chk("fill_wr_ready", 32'(bus.wr_ready), 32'd0);
            tick;
        end
        bus.clr = 1'b0;
    endtask
    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        #1;
        chk("wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("wr_we", 32'(bus.ram_we), 32'd1);
        chk("wr_addr", 32'(bus.ram_address), 32'(a));
        chk("wr_d", bus.ram_d, d);
        tick;
        bus.wr_valid = 1'b0;
    endtask
    task automatic rd(input logic [6:0] a, input logic [31:0] e);
        bus.rd_valid = 1'b1;
        bus.rd_addr = a;
        #1;
        chk("rd_ready", 32'(bus.rd_ready), 32'd1);
        chk("rd_we", 32'(bus.ram_we), 32'd0);
        chk("rd_addr", 32'(bus.ram_address), 32'(a));
        tick;
        bus.rd_valid = 1'b0;
        #1;
        chk("rsp_early", 32'(bus.rsp_valid), 32'd0);
        tick;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_data", bus.rsp_data, e);
    endtask
    initial begin
        bus.clr = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_valid = 1'b0;
        bus.rd_addr = '0;
        tick;
        poison = 1'b0;
        tick;
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_rd_ready", 32'(bus.rd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_we", 32'(bus.ram_we), 32'd0);
        reset = 1'b0;
        fill(128, -1);
        chk("run_busy", 32'(bus.busy), 32'd0);
        chk("run_wr_ready", 32'(bus.wr_ready), 32'd1);
        rd(7'd0, 32'd0);
        rd(7'd64, 32'd0);
        rd(7'd127, 32'd0);
        wr(7'd5, 32'hDEAD_BEEF);
        rd(7'd5, 32'hDEAD_BEEF);
        wr(7'd1, 32'h11);
        wr(7'd2, 32'h22);
        wr(7'd3, 32'h33);
        bus.rd_valid = 1'b1;
        bus.rd_addr = 7'd1;
        tick;
        bus.rd_addr = 7'd2;
        #1;
        chk("stream_v0", 32'(bus.rsp_valid), 32'd0);
        tick;
        bus.rd_addr = 7'd3;
        #1;
        chk("stream_v1", 32'(bus.rsp_valid), 32'd1);
        chk("stream_d1", bus.rsp_data, 32'h11);
        tick;
        bus.rd_valid = 1'b0;
        #1;
        chk("stream_v2", 32'(bus.rsp_valid), 32'd1);
        chk("stream_d2", bus.rsp_data, 32'h22);
        tick;
        chk("stream_v3", 32'(bus.rsp_valid), 32'd1);
        chk("stream_d3", bus.rsp_data, 32'h33);
        tick;
        chk("stream_v4", 32'(bus.rsp_valid), 32'd0);
        chk("stream_hold", bus.rsp_data, 32'h33);
        bus.wr_valid = 1'b1;
        bus.wr_addr = 7'd20;
        bus.wr_data = 32'h77;
        bus.rd_valid = 1'b1;
        bus.rd_addr = 7'd5;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("arb_we", 32'(bus.ram_we), 32'(k % 2 == 0));
            chk("arb_wr_ready", 32'(bus.wr_ready), 32'(k % 2 == 0));
            chk("arb_rd_ready", 32'(bus.rd_ready), 32'(k % 2 == 1));
            if (k == 3) begin
                chk("arb_rsp_v", 32'(bus.rsp_valid), 32'd1);
                chk("arb_rsp_d", bus.rsp_data, 32'hDEAD_BEEF);
            end
            tick;
        end
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        #1;
        chk("arb_rsp_gap", 32'(bus.rsp_valid), 32'd0);
        tick;
        chk("arb_rsp_v2", 32'(bus.rsp_valid), 32'd1);
        chk("arb_rsp_d2", bus.rsp_data, 32'hDEAD_BEEF);
        rd(7'd20, 32'h77);
        wr(7'd9, 32'hA5);
        bus.rd_valid = 1'b1;
        bus.rd_addr = 7'd9;
        #1;
        chk("clr_rd_ready", 32'(bus.rd_ready), 32'd1);
        tick;
        bus.rd_valid = 1'b0;
        bus.wr_valid = 1'b1;
        bus.clr = 1'b1;
        #1;
        chk("clr_we", 32'(bus.ram_we), 32'd0);
        chk("clr_wr_ready", 32'(bus.wr_ready), 32'd0);
        tick;
        bus.clr = 1'b0;
        bus.wr_valid = 1'b0;
        chk("clr_busy", 32'(bus.busy), 32'd1);
        chk("clr_rsp_v", 32'(bus.rsp_valid), 32'd1);
        chk("clr_rsp_d", bus.rsp_data, 32'hA5);
        fill(128, 10);
        chk("clr_done_busy", 32'(bus.busy), 32'd0);
        rd(7'd9, 32'd0);
        rd(7'd5, 32'd0);
        bus.clr = 1'b1;
        tick;
        bus.clr = 1'b0;
        fill(60, -1);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", 32'(bus.ram_we), 32'd0);
        tick;
        reset = 1'b0;
        fill(128, -1);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        rd(7'd20, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
